// File: rtl/alu_wb_unit.sv
// Single-cycle integer ALU feeding a WB_DEPTH-entry writeback queue toward the CDB; results appear one cycle after dispatch.
// alu_full rises one entry early; a dispatch into a full queue without a same-cycle pop is dropped and flagged in overflow_err.
`ifndef RS_TYPE_BIT
`define RS_TYPE_BIT 5
`endif
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module wb_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_dat,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= wr_dat;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign rd_dat = mem[rd_ptr];
endmodule

module alu_wb_unit #(
  parameter int WB_DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     rob_clear,
  input  logic                     alu_valid,
  input  logic [31:0]              alu_r1,
  input  logic [31:0]              alu_r2,
  input  logic [`RS_TYPE_BIT-1:0]  alu_op,
  input  logic [`ROB_SIZE_BIT-1:0] alu_rob_idx,
  output logic                     alu_full,
  input  logic                     wb_grant,
  output logic                     alu_wb_valid,
  output logic [`ROB_SIZE_BIT-1:0] alu_wb_idx,
  output logic [31:0]              alu_wb_value,
  output logic                     overflow_err
);
  localparam int CW = $clog2(WB_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(WB_DEPTH);
  localparam logic [CW-1:0] FULL_TH_C = CW'(WB_DEPTH - 1);

  typedef struct packed {
    logic [`ROB_SIZE_BIT-1:0] idx;
    logic [31:0]              value;
  } wb_entry_t;

  wb_entry_t       push_dat;
  wb_entry_t       head_dat;
  logic [CW-1:0]   count;
  logic [31:0]     result;
  logic [4:0]      shamt;
  logic            lt_s;
  logic            lt_u;
  logic            active;
  logic            pop;
  logic            push;
  logic            drop;
  logic            unused_op_hi;

  assign unused_op_hi = ^alu_op[`RS_TYPE_BIT-1:4];

  assign shamt = alu_r2[4:0];
  assign lt_s  = $signed(alu_r1) < $signed(alu_r2);
  assign lt_u  = alu_r1 < alu_r2;

  always_comb begin
    result = 32'd0;
    case (alu_op[3:0])
      4'd0:    result = alu_r1 + alu_r2;
      4'd1:    result = alu_r1 - alu_r2;
      4'd2:    result = alu_r1 & alu_r2;
      4'd3:    result = alu_r1 | alu_r2;
      4'd4:    result = alu_r1 ^ alu_r2;
      4'd5:    result = alu_r1 << shamt;
      4'd6:    result = alu_r1 >> shamt;
      4'd7:    result = $unsigned($signed(alu_r1) >>> shamt);
      4'd8:    result = {31'd0, lt_s};
      4'd9:    result = {31'd0, lt_u};
      4'd10:   result = {31'd0, alu_r1 == alu_r2};
      4'd11:   result = {31'd0, alu_r1 != alu_r2};
      4'd12:   result = {31'd0, !lt_s};
      4'd13:   result = {31'd0, !lt_u};
      default: result = 32'd0;
    endcase
  end

  // A flush takes priority over any same-cycle dispatch or grant.
  assign active = rdy_in && !rob_clear;
  assign pop    = active && alu_wb_valid && wb_grant;
  assign push   = active && alu_valid && ((count < DEPTH_C) || pop);
  assign drop   = active && alu_valid && (count == DEPTH_C) && !pop;

  assign push_dat.idx   = alu_rob_idx;
  assign push_dat.value = result;

  wb_fifo #(
    .W     ($bits(wb_entry_t)),
    .DEPTH (WB_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .en       (rdy_in),
    .clr      (rob_clear),
    .push     (push),
    .pop      (pop),
    .wr_dat   (push_dat),
    .rd_dat   (head_dat),
    .count    (count)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)  overflow_err <= 1'b0;
    else if (drop)  overflow_err <= 1'b1;
  end

  assign alu_wb_valid = (count != '0);
  assign alu_wb_idx   = head_dat.idx;
  assign alu_wb_value = head_dat.value;
  assign alu_full     = (count >= FULL_TH_C);
endmodule

// File: tb/tb_alu_wb_unit.sv
// Scoreboarded bench for alu_wb_unit: expected writebacks are queued at dispatch and compared at the queue head.
`ifndef RS_TYPE_BIT
`define RS_TYPE_BIT 5
`endif
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module tb_alu_wb_unit;
  localparam int DEPTH = 4;

  logic                     clk_in = 1'b0;
  logic                     rst_n_in;
  logic                     rdy_in;
  logic                     rob_clear;
  logic                     alu_valid;
  logic [31:0]              alu_r1;
  logic [31:0]              alu_r2;
  logic [`RS_TYPE_BIT-1:0]  alu_op;
  logic [`ROB_SIZE_BIT-1:0] alu_rob_idx;
  logic                     alu_full;
  logic                     wb_grant;
  logic                     alu_wb_valid;
  logic [`ROB_SIZE_BIT-1:0] alu_wb_idx;
  logic [31:0]              alu_wb_value;
  logic                     overflow_err;

  int checks   = 0;
  int failures = 0;
  logic [35:0] sb[$];
  logic        ovf_exp = 1'b0;

  alu_wb_unit #(.WB_DEPTH(DEPTH)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .rob_clear    (rob_clear),
    .alu_valid    (alu_valid),
    .alu_r1       (alu_r1),
    .alu_r2       (alu_r2),
    .alu_op       (alu_op),
    .alu_rob_idx  (alu_rob_idx),
    .alu_full     (alu_full),
    .wb_grant     (wb_grant),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_idx   (alu_wb_idx),
    .alu_wb_value (alu_wb_value),
    .overflow_err (overflow_err)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op[3:0])
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return 32'($signed(a) >>> sh);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return (a == b) ? 32'd1 : 32'd0;
      4'd11: return (a != b) ? 32'd1 : 32'd0;
      4'd12: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd13: return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_outputs();
    check_eq("wb_valid", 64'(alu_wb_valid), 64'(sb.size() != 0));
    check_eq("full", 64'(alu_full), 64'(sb.size() >= DEPTH - 1));
    check_eq("overflow", 64'(overflow_err), 64'(ovf_exp));
    if (sb.size() != 0) begin
      check_eq("head_idx", 64'(alu_wb_idx), 64'(sb[0][35:32]));
      check_eq("head_val", 64'(alu_wb_value), 64'(sb[0][31:0]));
    end
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance the model at posedge.
  task automatic step(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] idx, input logic g, input logic clr, input logic rdy);
    logic pop;
    logic acc;
    alu_valid = v; alu_op = op; alu_r1 = a; alu_r2 = b; alu_rob_idx = idx;
    wb_grant = g; rob_clear = clr; rdy_in = rdy;
    @(negedge clk_in);
    check_outputs();
    @(posedge clk_in);
    if (rdy) begin
      if (clr) begin
        sb.delete();
      end else begin
        pop = g && (sb.size() != 0);
        acc = v && ((sb.size() < DEPTH) || pop);
        if (v && !acc) ovf_exp = 1'b1;
        if (pop) void'(sb.pop_front());
        if (acc) sb.push_back({idx, alu_ref(op, a, b)});
      end
    end
    #1;
  endtask

  task automatic idle(input logic g);
    step(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, g, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) idle(1'b1);
    check_eq("drained", 64'(alu_wb_valid), 64'd0);
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0; alu_valid = 1'b0;
    alu_r1 = '0; alu_r2 = '0; alu_op = '0; alu_rob_idx = '0; wb_grant = 1'b0;
    #2;
    check_eq("rst_valid", 64'(alu_wb_valid), 64'd0);
    check_eq("rst_idx", 64'(alu_wb_idx), 64'd0);
    check_eq("rst_value", 64'(alu_wb_value), 64'd0);
    check_eq("rst_full", 64'(alu_full), 64'd0);
    check_eq("rst_ovf", 64'(overflow_err), 64'd0);
    #10 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // ADD wraps to 0 and is gone one cycle after the grant
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 32'd1, 4'd3, 1'b1, 1'b0, 1'b1);
    check_eq("add_valid", 64'(alu_wb_valid), 64'd1);
    check_eq("add_idx", 64'(alu_wb_idx), 64'd3);
    check_eq("add_value", 64'(alu_wb_value), 64'd0);
    idle(1'b1);
    check_eq("add_popped", 64'(alu_wb_valid), 64'd0);

    // SRA then SLT, delivered in order
    step(1'b1, 5'd7, 32'h8000_0000, 32'h21, 4'd5, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd8, 32'hFFFF_FFFF, 32'd0, 4'd6, 1'b0, 1'b0, 1'b1);
    check_eq("sra_value", 64'(alu_wb_value), 64'hC000_0000);
    idle(1'b1);
    check_eq("slt_value", 64'(alu_wb_value), 64'd1);
    check_eq("slt_idx", 64'(alu_wb_idx), 64'd6);
    idle(1'b1);

    // assorted ops through the scoreboard
    for (int op = 0; op < 16; op++) begin
      step(1'b1, 5'(op), $urandom, (op % 3 == 0) ? 32'h1234_5678 : $urandom, 4'(op), 1'b1, 1'b0, 1'b1);
    end
    drain();

    // full queue: dispatch with a same-cycle pop is accepted without overflow
    for (int i = 10; i < 14; i++) step(1'b1, 5'd2, 32'hFF, 32'(i), 4'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd0, 32'd7, 32'd0, 4'd7, 1'b1, 1'b0, 1'b1);
    check_eq("pp_full", 64'(alu_full), 64'd1);
    check_eq("pp_ovf", 64'(overflow_err), 64'd0);
    check_eq("pp_head", 64'(alu_wb_idx), 64'd11);
    drain();

    // flush with 2 entries and a same-cycle dispatch
    step(1'b1, 5'd3, 32'd1, 32'd2, 4'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd4, 32'd5, 32'd6, 4'd2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd0, 32'd9, 32'd9, 4'd8, 1'b1, 1'b1, 1'b1);
    check_eq("clr_valid", 64'(alu_wb_valid), 64'd0);
    check_eq("clr_full", 64'(alu_full), 64'd0);
    step(1'b1, 5'd0, 32'd40, 32'd2, 4'd3, 1'b0, 1'b0, 1'b1);
    check_eq("post_clr_idx", 64'(alu_wb_idx), 64'd3);
    check_eq("post_clr_val", 64'(alu_wb_value), 64'd42);
    drain();

    // fill without grants, drop the fifth, then drain in order
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 5'd5, 32'd1, 32'(i), 4'(i), 1'b0, 1'b0, 1'b1);
      if (i == 3) check_eq("full_after3", 64'(alu_full), 64'd1);
    end
    step(1'b1, 5'd0, 32'd1, 32'd1, 4'd9, 1'b0, 1'b0, 1'b1);
    check_eq("drop_ovf", 64'(overflow_err), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain_idx", 64'(alu_wb_idx), 64'(i));
      idle(1'b1);
    end
    check_eq("drain_empty", 64'(alu_wb_valid), 64'd0);

    // rdy_in low freezes everything, including flush
    step(1'b1, 5'd1, 32'd10, 32'd3, 4'd4, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd6, 32'h100, 32'd4, 4'd5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 32'd1, 32'd1, 4'd6, 1'b1, (i == 1), 1'b0);
    check_eq("frz_head", 64'(alu_wb_idx), 64'd4);
    check_eq("frz_val", 64'(alu_wb_value), 64'd7);
    idle(1'b0);

    // asynchronous reset mid-cycle
    #2 rst_n_in = 1'b0;
    #1;
    check_eq("arst_valid", 64'(alu_wb_valid), 64'd0);
    check_eq("arst_idx", 64'(alu_wb_idx), 64'd0);
    check_eq("arst_value", 64'(alu_wb_value), 64'd0);
    check_eq("arst_full", 64'(alu_full), 64'd0);
    check_eq("arst_ovf", 64'(overflow_err), 64'd0);
    sb.delete();
    ovf_exp = 1'b0;
    #2 rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    step(1'b1, 5'd9, 32'd1, 32'hFFFF_FFFF, 4'd12, 1'b0, 1'b0, 1'b1);
    check_eq("resume_val", 64'(alu_wb_value), 64'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_wb_unit.md
ALU_WB_UNIT -- requirements
Module: alu_wb_unit

Interface
REQ-001 SHALL have parameter WB_DEPTH, default 4, writeback queue depth (power of two, >= 2).
REQ-002 SHALL have port clk_in  input  1  system clock; the block uses one clock.
REQ-003 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-005 SHALL have port rob_clear  input  1  pipeline flush.
REQ-006 SHALL have port alu_valid  input  1  dispatch valid from reservation station.
REQ-007 SHALL have port alu_r1  input  32  operand 1.
REQ-008 SHALL have port alu_r2  input  32  operand 2.
REQ-009 SHALL have port alu_op  input  `RS_TYPE_BIT  operation; low 4 bits decoded.
REQ-010 SHALL have port alu_rob_idx  input  `ROB_SIZE_BIT  destination ROB index.
REQ-011 SHALL have port alu_full  output  1  dispatch backpressure to reservation station.
REQ-012 SHALL have port wb_grant  input  1  CDB arbiter grant for the head entry.
REQ-013 SHALL have port alu_wb_valid  output  1  writeback valid (queue non-empty).
REQ-014 SHALL have port alu_wb_idx  output  `ROB_SIZE_BIT  writeback ROB index (queue head).
REQ-015 SHALL have port alu_wb_value  output  32  writeback value (queue head).
REQ-016 SHALL have port overflow_err  output  1  sticky flag: dispatch dropped on full queue.

Function
REQ-017 SHALL decode op[3:0]: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 EQ, 11 NE, 12 GE (signed), 13 GEU; 14/15 produce 0.
REQ-018 SHALL use alu_r2[4:0] as shift amount; ADD/SUB wrap modulo 2^32; compare ops yield 32'd1 or 32'd0.
REQ-019 SHALL compute the result combinationally and push {rob_idx, result} into a WB_DEPTH-entry FIFO at the clock edge where alu_valid=1 is accepted.
REQ-020 SHALL have latency 1: an entry pushed into an empty queue shows alu_wb_valid=1 with its data in the following cycle.
REQ-021 SHALL drive alu_wb_valid = (count != 0) and alu_wb_idx/alu_wb_value from the head entry, all from registers only.
REQ-022 SHALL pop the head at an edge where alu_wb_valid=1 and wb_grant=1; wb_grant with alu_wb_valid=0 has no effect.
REQ-023 SHALL accept a dispatch when count < WB_DEPTH, or when count == WB_DEPTH and a pop occurs in the same cycle.
REQ-024 SHALL, on simultaneous push and pop, leave count unchanged and preserve FIFO order.
REQ-025 SHALL drop a dispatch arriving with count == WB_DEPTH and no pop, and set overflow_err, which stays 1 until reset.
REQ-026 SHALL assert alu_full combinationally when count >= WB_DEPTH-1, so one dispatch issued in the cycle alu_full rises still fits.
REQ-027 SHALL wrap read/write pointers modulo WB_DEPTH; count is $clog2(WB_DEPTH)+1 bits wide.
REQ-028 SHALL, when rob_clear=1 and rdy_in=1, empty the queue (count and pointers to 0), ignore same-cycle dispatch and pop, and keep overflow_err.
REQ-029 SHALL, when rdy_in=0, hold every register, perform no push or pop, and ignore rob_clear.

Reset
REQ-030 SHALL, on rst_n_in low (asynchronous), clear pointers, count, queue contents and overflow_err; outputs become alu_wb_valid=0, alu_wb_idx=0, alu_wb_value=0, alu_full=0, overflow_err=0.
REQ-031 SHALL resume normal operation at the first rising clk_in after rst_n_in returns high.

Verification
REQ-032 SHALL verify: dispatch ADD r1=0xFFFFFFFF r2=1 idx=3, wb_grant=1 -> next cycle alu_wb_valid=1, idx=3, value=0; one cycle later alu_wb_valid=0.
REQ-033 SHALL verify: SRA r1=0x80000000 r2=0x21, and SLT r1=-1 r2=0 -> values 0xC0000000 and 1, delivered in dispatch order.
REQ-034 SHALL verify: wb_grant=0, dispatch 4 ops idx 1..4 -> alu_full=1 after the third push; fifth dispatch with no grant -> dropped, overflow_err=1; grants then return idx 1,2,3,4.
REQ-035 SHALL verify: queue full, dispatch idx 7 with wb_grant=1 -> head popped, idx 7 accepted, count stays 4, overflow_err=0.
REQ-036 SHALL verify: 2 entries queued, rob_clear=1 plus a dispatch -> next cycle alu_wb_valid=0, alu_full=0; dispatch in the cycle after is accepted normally.
REQ-037 SHALL verify: rdy_in=0 for 3 cycles with alu_valid=1 and wb_grant=1 -> no count change; rst_n_in pulsed low mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
